// File: rtl/capture_pkg.sv
// capture_pkg: types and constants shared by the capture FSM and the dump sequencer
package capture_pkg;
   localparam int CAP_ADDR_W = 9;
   localparam int CAP_DATA_W = 8;
   localparam int CAP_CH_W = 3;
   localparam int DEPTH = 2 ** CAP_ADDR_W;
   localparam logic [4:0] HDR_TAG = 5'b10100;
   typedef logic [CAP_ADDR_W-1:0] Address;
   typedef enum logic [2:0] {IDLE, RD, WAIT, SEND, TXW, FIN} DumpState;
endpackage

// File: rtl/dump_addr_ctr.sv
// dump_addr_ctr: read address (loads trace_end+1, wraps naturally) and sample count with terminal flag
module dump_addr_ctr import capture_pkg::*; #(
   parameter int ADDR_W = CAP_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_inc,
   input  logic [ADDR_W-1:0] i_trace_end,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);
   logic [ADDR_W-1:0] r_cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         o_addr <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         o_addr <= i_trace_end + ADDR_W'(1);
         r_cnt <= '0;
      end else if (i_inc) begin
         o_addr <= o_addr + ADDR_W'(1);
         r_cnt <= r_cnt + ADDR_W'(1);
      end
   assign o_last = &r_cnt;
endmodule

// File: rtl/dump_ctrl.sv
// dump_ctrl: streams one channel of the capture RAM, oldest to newest, to the UART.
// Optional DUMP_HDR_EN prepends a {HDR_TAG, channel} header byte.
module dump_ctrl import capture_pkg::*; #(
   parameter int ADDR_W = CAP_ADDR_W,
   parameter int DATA_W = CAP_DATA_W,
   parameter int CH_W = CAP_CH_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_dump,
   input  logic [CH_W-1:0]   dump_ch,
   input  logic              capture_done,
   input  logic [ADDR_W-1:0] trace_end,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [CH_W-1:0]   ch_sel,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   input  logic              tx_done,
   output logic              busy,
   output logic              dump_finished,
   output logic              clr_capture_done
);
   DumpState r_state;
   logic w_accept, w_inc, w_last, w_hdr;
   assign w_accept = (r_state == IDLE) && start_dump && capture_done;
   assign w_inc = (r_state == TXW) && tx_done && !w_last && !w_hdr;
`ifdef DUMP_HDR_EN
   logic r_hdr;
   assign w_hdr = r_hdr;
   // header byte pending: its tx_done must not advance the address
   always_ff @(posedge clk or posedge rst)
      if (rst) r_hdr <= 1'b0;
      else if (w_accept) r_hdr <= 1'b1;
      else if (r_state == TXW && tx_done) r_hdr <= 1'b0;
`else
   assign w_hdr = 1'b0;
`endif
   dump_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
      .clk(clk),
      .rst(rst),
      .i_load(w_accept),
      .i_inc(w_inc),
      .i_trace_end(trace_end),
      .o_addr(ram_addr),
      .o_last(w_last)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         ram_en <= 1'b0;
         ch_sel <= '0;
         tx_data <= '0;
         tx_start <= 1'b0;
         busy <= 1'b0;
         dump_finished <= 1'b0;
         clr_capture_done <= 1'b0;
      end else begin
         ram_en <= 1'b0;
         tx_start <= 1'b0;
         dump_finished <= 1'b0;
         clr_capture_done <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               ch_sel <= dump_ch;
               busy <= 1'b1;
`ifdef DUMP_HDR_EN
               tx_data <= DATA_W'({HDR_TAG, dump_ch});
               tx_start <= 1'b1;
               r_state <= SEND;
`else
               ram_en <= 1'b1;
               r_state <= RD;
`endif
            end
            RD: r_state <= WAIT;
            WAIT: begin
               tx_data <= ram_rdata;
               tx_start <= 1'b1;
               r_state <= SEND;
            end
            SEND: r_state <= TXW;
            TXW: if (tx_done) begin
               if (w_last && !w_hdr) begin
                  dump_finished <= 1'b1;
                  clr_capture_done <= 1'b1;
                  r_state <= FIN;
               end else begin
                  ram_en <= 1'b1;
                  r_state <= RD;
               end
            end
            FIN: begin
               busy <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_dump_ctrl.sv
// tb_dump_ctrl: randomized RAM contents and trace positions checked against a sequence model of the dump
module tb_dump_ctrl;
   import capture_pkg::*;
`ifdef DUMP_HDR_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic       start_dump = 1'b0, capture_done = 1'b0, uart_done = 1'b0, spur_done = 1'b0, tx_done;
   logic [2:0] dump_ch = '0, ch_sel;
   logic [8:0] trace_end = '0, ram_addr;
   logic [7:0] ram_rdata = '0, tx_data;
   logic       ram_en, tx_start, busy, dump_finished, clr_capture_done;
   assign tx_done = uart_done | spur_done;
   dump_ctrl dut (
      .clk(clk), .rst(rst), .start_dump(start_dump), .dump_ch(dump_ch),
      .capture_done(capture_done), .trace_end(trace_end), .ram_en(ram_en),
      .ram_addr(ram_addr), .ch_sel(ch_sel), .ram_rdata(ram_rdata), .tx_data(tx_data),
      .tx_start(tx_start), .tx_done(tx_done), .busy(busy),
      .dump_finished(dump_finished), .clr_capture_done(clr_capture_done)
   );
   logic [7:0] mem [8][DEPTH];
   always @(posedge clk) if (ram_en) ram_rdata <= mem[ch_sel][ram_addr];
   int checks = 0, errors = 0;
   int cyc = 0, last_evt = 0, ucnt = 0;
   int lat_err = 0, ch_err = 0, fin_cnt = 0, clr_cnt = 0, clr_mis = 0, act_cnt = 0, tx_cnt = 0;
   bit first = 1'b0;
   logic [2:0] cur_ch = '0;
   logic [7:0] got_q[$];
   int addr_q[$];
   // monitor plus UART model: tx_done 10 cycles after each tx_start
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         ucnt = 0;
         uart_done = 1'b0;
      end else begin
         if (start_dump && capture_done && !busy) begin
            got_q.delete(); addr_q.delete();
            cur_ch = dump_ch; last_evt = cyc; first = 1'b1;
            fin_cnt = 0; clr_cnt = 0; clr_mis = 0; tx_cnt = 0; lat_err = 0; ch_err = 0;
         end
         if (ram_en) addr_q.push_back(int'(ram_addr));
         if (tx_start) begin
            got_q.push_back(tx_data);
            tx_cnt++;
            if (cyc - last_evt != ((first && HDR == 1) ? 1 : 3)) lat_err++;
            first = 1'b0;
         end
         if (busy && ch_sel !== cur_ch) ch_err++;
         if (dump_finished) fin_cnt++;
         if (clr_capture_done) clr_cnt++;
         if (dump_finished !== clr_capture_done) clr_mis++;
         if (ram_en || tx_start || busy) act_cnt++;
         uart_done = 1'b0;
         if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) begin
               uart_done = 1'b1;
               last_evt = cyc;
            end
         end
         if (tx_start) ucnt = 10;
      end
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [24:0] outs();
      return {ram_en, ram_addr, ch_sel, tx_data, tx_start, busy, dump_finished, clr_capture_done};
   endfunction
   task automatic start(input logic [2:0] ch, input logic [8:0] te);
      @(posedge clk); #1;
      trace_end = te; dump_ch = ch; capture_done = 1'b1; start_dump = 1'b1;
      @(posedge clk); #1;
      start_dump = 1'b0;
   endtask
   task automatic run_dump(input logic [2:0] ch, input logic [8:0] te, input bit spur);
      start(ch, te);
      for (int i = 0; i < 12000 && fin_cnt == 0; i++) begin
         spur_done = 1'b0; start_dump = 1'b0; capture_done = 1'b1;
         if (spur && tx_start && $urandom_range(0, 3) == 0) begin
            spur_done = 1'b1; start_dump = 1'b1; dump_ch = ~ch;
            capture_done = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      spur_done = 1'b0; start_dump = 1'b0; capture_done = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask
   task automatic check_dump(input logic [2:0] ch, input logic [8:0] te);
      int bad;
      logic [7:0] e;
      chk("byte_count", 64'(got_q.size()), 64'(DEPTH + HDR));
      bad = 0;
      for (int i = 0; i < got_q.size() && i < DEPTH + HDR; i++) begin
         e = (HDR == 1 && i == 0) ? {5'b10100, ch} : mem[ch][(int'(te) + 1 + i - HDR) % DEPTH];
         if (got_q[i] !== e) bad++;
      end
      chk("tx_data_seq", 64'(bad), 0);
      chk("read_count", 64'(addr_q.size()), 64'(DEPTH));
      bad = 0;
      for (int i = 0; i < addr_q.size() && i < DEPTH; i++)
         if (addr_q[i] != (int'(te) + 1 + i) % DEPTH) bad++;
      chk("ram_addr_order", 64'(bad), 0);
      chk("ch_sel_held", 64'(ch_err), 0);
      chk("fin_pulses", 64'(fin_cnt), 1);
      chk("clr_pulses", 64'(clr_cnt), 1);
      chk("clr_coincident", 64'(clr_mis), 0);
      chk("latency", 64'(lat_err), 0);
      chk("busy_after", 64'(busy), 0);
   endtask
   initial begin
      logic [2:0] ch;
      logic [8:0] te;
      int act0;
      for (int c = 0; c < 8; c++)
         for (int a = 0; a < DEPTH; a++) mem[c][a] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'(outs()), 0);
      rst = 1'b0;
      run_dump(3'd2, 9'h1FF, 1'b0);
      check_dump(3'd2, 9'h1FF);
      ch = 3'($urandom);
      run_dump(ch, 9'h0A0, 1'b1);
      check_dump(ch, 9'h0A0);
      act0 = act_cnt;
      @(posedge clk); #1;
      capture_done = 1'b0; dump_ch = 3'd4; start_dump = 1'b1;
      @(posedge clk); #1;
      start_dump = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("no_capture_no_activity", 64'(act_cnt - act0), 0);
      ch = 3'($urandom);
      te = 9'($urandom);
      start(ch, te);
      for (int i = 0; i < 3000 && tx_cnt < 100; i++) begin
         @(posedge clk); #1;
      end
      chk("abort_bytes_sent", 64'(tx_cnt), 100);
      rst = 1'b1;
      #1;
      chk("abort_outputs", 64'(outs()), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_no_fin", 64'(fin_cnt), 0);
      rst = 1'b0;
      ch = 3'($urandom);
      te = 9'($urandom);
      run_dump(ch, te, 1'b0);
      check_dump(ch, te);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
